// File: rtl/font_text_renderer_if.sv
// font_text_renderer_if: pixel-stream inputs and glyph outputs of the text renderer
interface font_text_renderer_if #(parameter int NUM_CHARS = 4);
  logic                   frame_tick;
  logic                   video_on;
  logic [9:0]             pixel_x;
  logic [9:0]             pixel_y;
  logic [2*NUM_CHARS-1:0] text;
  logic                   blink_en;
  logic                   pixel_on;
  logic                   text_on;
  logic                   valid;
  modport master (
    output frame_tick, video_on, pixel_x, pixel_y, text, blink_en,
    input  pixel_on, text_on, valid
  );
  modport slave (
    input  frame_tick, video_on, pixel_x, pixel_y, text, blink_en,
    output pixel_on, text_on, valid
  );
endinterface

// File: rtl/font_text_renderer.sv
// font_text_renderer: scaled 8x16 glyph string in a fixed window with frame-synchronous text and blink
module font_text_renderer #(
  parameter int NUM_CHARS    = 4,
  parameter int SCALE_LOG2   = 0,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int BLINK_FRAMES = 30
) (
  input logic clk,
  input logic reset,
  font_text_renderer_if.slave bus
);
  localparam int W  = NUM_CHARS * 8 << SCALE_LOG2;
  localparam int H  = 16 << SCALE_LOG2;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [127:0] G_R = 128'hFFFFC3C3C3C3FFFFF0F8FCDCCEC7C7C3;
  localparam logic [127:0] G_E = 128'hFFFFFFC0C0C0FCFCC0C0C0C0C0FFFFFF;
  localparam logic [127:0] G_D = 128'hFCFEC7C3C3C3C3C3C3C3C3C3C3C7FEFC;
  logic [2*NUM_CHARS-1:0] shadow;
  logic [BW-1:0]          cnt;
  logic                   phase;
  logic [11:0]            dx, dy;
  logic [9:0]             rx;
  logic [3:0]             row;
  logic                   in_win;
  logic [1:0]             code;
  logic                   win1, vo1;
  logic [1:0]             code1;
  logic [3:0]             row1;
  logic [2:0]             col1;
  logic [7:0]             bits;
  // Window test via 12-bit difference: the borrow bit catches pixels left of / above the window
  always_comb begin
    dx     = {2'b00, bus.pixel_x} - 12'(X0);
    dy     = {2'b00, bus.pixel_y} - 12'(Y0);
    in_win = !dx[11] && dx[10:0] < 11'(W) && !dy[11] && dy[10:0] < 11'(H);
    rx     = dx[9:0] >> SCALE_LOG2;
    row    = 4'(dy[9:0] >> SCALE_LOG2);
    code   = '0;
    for (int i = 0; i < NUM_CHARS; i++)
      if (in_win && rx[9:3] == 7'(i)) code = shadow[2*i +: 2];
  end
  // Glyph ROM row lookup; row 0 is the most significant byte of each table
  always_comb begin
    bits = code1 == 2'd1 ? G_R[{~row1, 3'b000} +: 8] :
           code1 == 2'd2 ? G_E[{~row1, 3'b000} +: 8] :
           code1 == 2'd3 ? G_D[{~row1, 3'b000} +: 8] : 8'h00;
  end
  // Text shadow and blink counter advance only on frame boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      cnt    <= '0;
      phase  <= 1'b0;
    end else if (bus.frame_tick) begin
      shadow <= bus.text;
      cnt    <= cnt == BW'(BLINK_FRAMES - 1) ? '0 : cnt + 1'b1;
      phase  <= phase ^ (cnt == BW'(BLINK_FRAMES - 1));
    end
  end
  // Two-stage pixel pipeline: address/code capture, then ROM bit select and gating
  always_ff @(posedge clk) begin
    if (reset) begin
      win1         <= 1'b0;
      vo1          <= 1'b0;
      code1        <= '0;
      row1         <= '0;
      col1         <= '0;
      bus.pixel_on <= 1'b0;
      bus.text_on  <= 1'b0;
      bus.valid    <= 1'b0;
    end else begin
      win1         <= in_win;
      vo1          <= bus.video_on;
      code1        <= code;
      row1         <= row;
      col1         <= rx[2:0];
      bus.pixel_on <= bits[~col1] & win1 & vo1 & ~(bus.blink_en & phase);
      bus.text_on  <= win1 & vo1;
      bus.valid    <= vo1;
    end
  end
endmodule

// File: doc/font_text_renderer.md
Name: font_text_renderer

Overview:
- Parametrised successor to the team's fixed 3-glyph 8x16 font ROM.
- Renders a NUM_CHARS-long string of 8x16 glyphs inside a fixed screen window, with integer pixel scaling, a frame-synchronous text shadow register and optional blink.
- Sits between the VGA sync generator (pixel_x/pixel_y/video_on/frame_tick) and the RGB mux.
- Fixed 2-cycle pipeline latency.

Parameters:
- NUM_CHARS, 4: characters in the string; minimum 1.
- SCALE_LOG2, 0: glyph scale is 2^SCALE_LOG2; legal values 0..2.
- X0, 0: left pixel column of the text window.
- Y0, 0: top pixel row of the text window.
- BLINK_FRAMES, 30: frames per blink half-period; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of frame
- video_on  in  1  active display region
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- text  in  2*NUM_CHARS  glyph codes; char 0 = text[1:0] = leftmost
- blink_en  in  1  enable blinking
- pixel_on  out  1  glyph foreground at the pixel issued 2 cycles earlier
- text_on  out  1  pixel issued 2 cycles earlier lies inside the text window
- valid  out  1  video_on delayed 2 cycles

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: pixel_on=0, text_on=0, valid=0, all pipeline registers 0, text shadow 0 (all blank), blink counter 0, blink_phase 0.
- Glyph codes: 0=blank (all rows 00), 1='R', 2='E', 3='D'. Rows 0..15 in hex, MSB = leftmost pixel:
  - R: FF FF C3 C3 C3 C3 FF FF F0 F8 FC DC CE C7 C7 C3
  - E: FF FF FF C0 C0 C0 FC FC C0 C0 C0 C0 C0 FF FF FF
  - D: FC FE C7 C3 C3 C3 C3 C3 C3 C3 C3 C3 C3 C7 FE FC
- Glyph ROM: internal, combinational lookup on {code,row}.
- Text shadow: loaded from text on the cycle frame_tick=1, so the string never changes mid-frame. If reset and frame_tick are both high, reset wins.
- Window: W = NUM_CHARS*8<<SCALE_LOG2 and H = 16<<SCALE_LOG2. A pixel is in the window iff X0 <= pixel_x < X0+W and Y0 <= pixel_y < Y0+H. Compare unsigned in 11 bits so the bounds cannot overflow.
- Address generation:
  - rx = (pixel_x-X0)>>SCALE_LOG2
  - ry = (pixel_y-Y0)>>SCALE_LOG2
  - char index = rx>>3, bit column = rx[2:0], glyph row = ry[3:0]
- Pipeline stage 1 (registered): in_win, char code selected from the shadow by char index, glyph row, bit column, video_on. Outside the window the code is forced to 0.
- Pipeline stage 2 (registered):
  - pixel_on = ROM[code,row][7-bitcol] & in_win & video_on & ~(blink_en & blink_phase)
  - text_on = in_win & video_on
  - valid = video_on
- Latency: exactly 2 clk cycles from pixel_x/pixel_y/video_on to the outputs, regardless of SCALE_LOG2. Throughput is one pixel per cycle with no stalls.
- Blink counter:
  - On each frame_tick, counter increments.
  - When counter = BLINK_FRAMES-1 and frame_tick=1, counter wraps to 0 and blink_phase toggles.
  - Counter runs even when blink_en=0. blink_en only gates the output and takes effect on the stage-2 register.
- Boundary conditions:
  - Right and bottom window edges are exclusive.
  - pixel_x < X0 must not wrap into the window; handled by the unsigned compare.
  - Char index never exceeds NUM_CHARS-1 while in_win=1.
- Reset mid-frame: all outputs are 0 on the cycle after reset is asserted; the blank shadow persists until the next frame_tick.

Test Plan:
- Reset then idle, NUM_CHARS=4, text=8'b11_10_01_01, no frame_tick, scan row 0 -> pixel_on=0 everywhere (shadow blank); text_on=1 for x 0..31.
- Pulse frame_tick, scan y=2, x=0..7 with SCALE_LOG2=0 -> pixel_on sequence 1,1,0,0,0,0,1,1 (R row 2 = C3), appearing 2 cycles after each x.
- Same text, y=0, x=24..31 -> D row 0 = FC gives 1,1,1,1,1,1,0,0. x=32 -> text_on=0, pixel_on=0.
- SCALE_LOG2=1, X0=100, Y0=50: x=100/101 and y=50/51 give an identical pixel. x=99 -> text_on=0. y=50+32 -> text_on=0 (H=32).
- Change text mid-frame without frame_tick -> output unchanged until the next frame_tick, then new glyphs appear.
- blink_en=1, BLINK_FRAMES=2, issue 6 frame_ticks -> blink_phase toggles after tick 2 and tick 4. pixel_on is suppressed during frames 3-4 and reappears in frames 5-6. Reset asserted mid-line -> all outputs 0 one cycle later.
